// File: rtl/sipo_rx_if.sv
// Link and consumer bundle for the serial-in/parallel-out receiver.
// Handshake: data_valid stays high while data_out holds an unacknowledged word.
// A cycle with data_valid && data_ack consumes that word. The receiver may
// overwrite data_out with a newer word before it is acknowledged; overrun flags that.
interface sipo_rx_if #(
  parameter int WIDTH = 8
);
  logic             sr_clk;
  logic             data_in;
  logic             frame;
  logic             data_ack;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             frame_err;
  logic             overrun;
  logic             busy;
  logic             state_dbg;

  modport master (
    output sr_clk, data_in, frame, data_ack,
    input  data_out, data_valid, frame_err, overrun, busy, state_dbg
  );

  modport slave (
    input  sr_clk, data_in, frame, data_ack,
    output data_out, data_valid, frame_err, overrun, busy, state_dbg
  );
endinterface

// File: rtl/sipo_rx.sv
// Serial receiver for the 8-bit PISO link: synchronizes sr_clk/data_in/frame,
// reassembles words MSB-first and flags framing errors and overruns.
module sipo_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     reset,
  sipo_rx_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sr_chain, d_chain, f_chain;
  logic                   sr_prev;
  logic                   sr_sync, data_sync, frame_sync, sr_rise;
  logic [CW-1:0]          bit_cnt, cnt_n;
  logic [WIDTH-1:0]       shreg, shreg_n, shifted;
  logic [WIDTH-1:0]       dout_q, dout_n;
  logic                   dv_q, dv_n, ferr_q, ferr_n, ovr_q, ovr_n, busy_q;
  logic                   complete;

  // Equal-depth chains keep data_sync aligned with the sr_clk edge it belongs to.
  assign sr_sync    = sr_chain[SYNC_STAGES-1];
  assign data_sync  = d_chain[SYNC_STAGES-1];
  assign frame_sync = f_chain[SYNC_STAGES-1];
  assign sr_rise    = sr_sync & ~sr_prev;
  assign shifted    = {shreg[WIDTH-2:0], data_sync};

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_chain <= '0;
      d_chain  <= '0;
      f_chain  <= '0;
      sr_prev  <= 1'b0;
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sr_chain <= {sr_chain[SYNC_STAGES-2:0], bus.sr_clk};
      d_chain  <= {d_chain[SYNC_STAGES-2:0], bus.data_in};
      f_chain  <= {f_chain[SYNC_STAGES-2:0], bus.frame};
      sr_prev  <= sr_sync;
      state    <= state_n;
      bit_cnt  <= cnt_n;
      shreg    <= shreg_n;
      dout_q   <= dout_n;
      dv_q     <= dv_n;
      ferr_q   <= ferr_n;
      ovr_q    <= ovr_n;
      busy_q   <= (state_n == SHIFT);
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = bit_cnt;
    shreg_n  = shreg;
    dout_n   = dout_q;
    dv_n     = dv_q & ~bus.data_ack;
    ferr_n   = 1'b0;
    ovr_n    = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (frame_sync) state_n = SHIFT;
      end
      SHIFT: begin
        if (sr_rise) begin
          shreg_n = shifted;
          if (bit_cnt == LAST) begin
            // Completion beats a simultaneous ack: the new word is still unread.
            complete = 1'b1;
            dout_n   = shifted;
            dv_n     = 1'b1;
            ovr_n    = dv_q & ~bus.data_ack;
            cnt_n    = '0;
          end else begin
            cnt_n = bit_cnt + 1'b1;
          end
        end
        if (!frame_sync) begin
          state_n = IDLE;
          cnt_n   = '0;
          ferr_n  = !complete && (bit_cnt != '0);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.data_out   = dout_q;
  assign bus.data_valid = dv_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = busy_q;
  assign bus.state_dbg  = state;
endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: drives the serial link with slow sr_clk phases
// and checks words, handshake and error pulses against hand-computed values.
module tb_sipo_rx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  int ferr_cycles = 0;
  int ovr_cycles  = 0;
  int dv_rises    = 0;
  int busy_cycles = 0;
  logic dv_last   = 1'b0;

  int ferr_base, ovr_base, dv_base, busy_base;

  sipo_rx_if #(.WIDTH(8)) bus ();

  sipo_rx #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Pulse and edge monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.frame_err) ferr_cycles <= ferr_cycles + 1;
      if (bus.overrun) ovr_cycles <= ovr_cycles + 1;
      if (bus.busy) busy_cycles <= busy_cycles + 1;
      if (bus.data_valid && !dv_last) dv_rises <= dv_rises + 1;
    end
    dv_last <= bus.data_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.data_in = b;
    clks(10);
    bus.sr_clk = 1'b1;
    clks(10);
    bus.sr_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    bus.data_ack = 1'b1;
    @(negedge clk);
    bus.data_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clks(3);
    reset = 1'b0;
    clks(2);
  endtask

  task automatic snap();
    ferr_base = ferr_cycles;
    ovr_base  = ovr_cycles;
    dv_base   = dv_rises;
    busy_base = busy_cycles;
  endtask

  initial begin
    bus.sr_clk   = 1'b0;
    bus.data_in  = 1'b0;
    bus.frame    = 1'b0;
    bus.data_ack = 1'b0;
    clks(3);
    chk("rst_data_out", 32'(bus.data_out), 32'h0);
    chk("rst_valid", 32'(bus.data_valid), 32'h0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
    chk("rst_overrun", 32'(bus.overrun), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    reset = 1'b0;
    clks(2);

    // Single word 0xC9 with exact completion latency on the last bit.
    snap();
    bus.frame = 1'b1;
    clks(5);
    chk("t1_busy", 32'(bus.busy), 32'h1);
    for (int i = 7; i >= 1; i--) send_bit(1'((8'hC9 >> i) & 8'h1));
    bus.data_in = 1'b1;
    clks(10);
    bus.sr_clk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 chk("t1_valid_early", 32'(bus.data_valid), 32'h0);
    @(posedge clk);
    #1 chk("t1_valid", 32'(bus.data_valid), 32'h1);
    chk("t1_data", 32'(bus.data_out), 32'hC9);
    clks(10);
    bus.sr_clk = 1'b0;
    clks(5);
    bus.frame = 1'b0;
    clks(6);
    chk("t1_idle", 32'(bus.busy), 32'h0);
    chk("t1_no_ferr", 32'(ferr_cycles - ferr_base), 32'h0);
    chk("t1_no_ovr", 32'(ovr_cycles - ovr_base), 32'h0);
    ack_pulse();
    chk("t1_ack_clears", 32'(bus.data_valid), 32'h0);

    // Two words in one frame, acknowledged between them.
    snap();
    bus.frame = 1'b1;
    clks(5);
    send_byte(8'h2A);
    clks(3);
    chk("t2_valid_a", 32'(bus.data_valid), 32'h1);
    chk("t2_data_a", 32'(bus.data_out), 32'h2A);
    ack_pulse();
    chk("t2_ack_a", 32'(bus.data_valid), 32'h0);
    send_byte(8'hC9);
    clks(3);
    chk("t2_valid_b", 32'(bus.data_valid), 32'h1);
    chk("t2_data_b", 32'(bus.data_out), 32'hC9);
    bus.frame = 1'b0;
    clks(6);
    chk("t2_idle", 32'(bus.state_dbg), 32'h0);
    chk("t2_rises", 32'(dv_rises - dv_base), 32'h2);
    chk("t2_no_ovr", 32'(ovr_cycles - ovr_base), 32'h0);
    ack_pulse();

    // Two words, never acknowledged: one single-cycle overrun.
    snap();
    bus.frame = 1'b1;
    clks(5);
    send_byte(8'h2A);
    clks(3);
    chk("t3_no_ovr_first", 32'(ovr_cycles - ovr_base), 32'h0);
    send_byte(8'hC9);
    clks(3);
    chk("t3_ovr_once", 32'(ovr_cycles - ovr_base), 32'h1);
    chk("t3_data", 32'(bus.data_out), 32'hC9);
    chk("t3_valid", 32'(bus.data_valid), 32'h1);
    bus.frame = 1'b0;
    clks(6);
    ack_pulse();

    // Frame drops after 5 bits of 0xFF, then a clean 0x55 frame.
    do_reset();
    snap();
    bus.frame = 1'b1;
    clks(5);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    bus.frame = 1'b0;
    clks(6);
    chk("t4_ferr_once", 32'(ferr_cycles - ferr_base), 32'h1);
    chk("t4_valid", 32'(bus.data_valid), 32'h0);
    chk("t4_data", 32'(bus.data_out), 32'h0);
    chk("t4_busy", 32'(bus.busy), 32'h0);
    bus.frame = 1'b1;
    clks(5);
    send_byte(8'h55);
    clks(3);
    chk("t4_data_55", 32'(bus.data_out), 32'h55);
    chk("t4_valid_55", 32'(bus.data_valid), 32'h1);
    chk("t4_ferr_still", 32'(ferr_cycles - ferr_base), 32'h1);
    bus.frame = 1'b0;
    clks(6);
    ack_pulse();

    // Reset mid-word, then 0xA5 must arrive without stale bits.
    bus.frame = 1'b1;
    clks(5);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    @(negedge clk);
    reset = 1'b1;
    bus.frame = 1'b0;
    @(posedge clk);
    #1 chk("t5_data", 32'(bus.data_out), 32'h0);
    chk("t5_valid", 32'(bus.data_valid), 32'h0);
    chk("t5_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    clks(3);
    bus.frame = 1'b1;
    clks(5);
    send_byte(8'hA5);
    clks(3);
    chk("t5_data_a5", 32'(bus.data_out), 32'hA5);
    chk("t5_valid_a5", 32'(bus.data_valid), 32'h1);
    bus.frame = 1'b0;
    clks(6);
    ack_pulse();

    // sr_clk activity with frame low must be ignored.
    snap();
    send_byte(8'hFF);
    clks(3);
    chk("t6_busy", 32'(busy_cycles - busy_base), 32'h0);
    chk("t6_valid", 32'(bus.data_valid), 32'h0);
    chk("t6_data", 32'(bus.data_out), 32'hA5);
    chk("t6_no_ferr", 32'(ferr_cycles - ferr_base), 32'h0);
    chk("t6_no_ovr", 32'(ovr_cycles - ovr_base), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in/parallel-out receiver that terminates the serial link driven by the team's 8-bit PISO transmitter. It samples that stage's serial data, shift-clock and load/frame lines, all treated as asynchronous inputs, in the single system clock domain. It reassembles bytes MSB-first and presents each completed byte on a parallel output with a valid/acknowledge handshake. Framing errors and overruns are flagged as single-cycle pulses.

## Interface
- WIDTH, 8, bits per word; the bit counter is $clog2(WIDTH) bits wide.
- SYNC_STAGES, 2, flip-flops in each input synchronizer (minimum 2).
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- sr_clk  input  1  transmitter shift clock, asynchronous; a rising edge marks one valid serial bit.
- data_in  input  1  serial data from the transmitter's data_out, asynchronous.
- frame  input  1  transmitter load/frame line, asynchronous; high for the whole duration of a transfer.
- data_ack  input  1  consumer acknowledge; clears data_valid.
- data_out  output  WIDTH  last completed word, MSB = first bit received.
- data_valid  output  1  high while data_out holds an unacknowledged word.
- frame_err  output  1  one-cycle pulse: frame fell mid-word.
- overrun  output  1  one-cycle pulse: a word completed while data_valid was still high.
- busy  output  1  high when state is SHIFT.

## Operation
- Synchronizers: sr_clk, data_in and frame each pass through a SYNC_STAGES-deep chain. One extra flop on synchronized sr_clk (sr_prev) provides edge detect: sr_rise = sr_sync & ~sr_prev. All three chains have equal depth, so data stays aligned with its clock.
- States:
  - IDLE: bit_cnt = 0, shift register untouched. Go to SHIFT when synchronized frame = 1. sr_rise is ignored in IDLE, including in the cycle frame is first seen high.
  - SHIFT: on sr_rise, shreg <= {shreg[WIDTH-2:0], data_sync} and bit_cnt++.
- Word completion, on the WIDTH-th sr_rise:
  - data_out <= completed word, data_valid <= 1, bit_cnt <= 0, remain in SHIFT.
  - Back-to-back words within one frame are supported.
- Frame fall in SHIFT:
  - With bit_cnt = 0: go to IDLE silently.
  - With bit_cnt != 0: pulse frame_err, discard the partial word, bit_cnt <= 0, go to IDLE. data_out and data_valid are unchanged.
- Simultaneous events:
  - Frame fall in the same cycle as the completing sr_rise: the word completes normally with no frame_err, then go to IDLE.
  - data_ack in the same cycle as a completion: completion wins; data_valid stays 1, data_out takes the new word, no overrun.
  - Completion while data_valid = 1 and no data_ack: data_out is overwritten, data_valid stays 1, overrun pulses.
  - data_ack with data_valid = 0: no effect.
- Reset, including mid-word: state IDLE, bit_cnt 0, shreg 0, data_out 0, data_valid 0, frame_err 0, overrun 0, busy 0. Synchronizer flops clear to 0.

## Timing
- An sr_clk rising edge first captured at clk edge N produces sr_rise during cycle N+SYNC_STAGES-1. The shift register updates at edge N+SYNC_STAGES; with defaults this is edge N+2.
- data_valid and data_out update on the same edge as the final shift, with no additional latency.
- frame_err and overrun are high for exactly one clk cycle.
- Data must be stable for at least SYNC_STAGES+1 clk cycles around each sr_clk rising edge.
- sr_clk high and low phases must each last at least SYNC_STAGES+1 clk cycles; faster shift clocks are unsupported.
- frame must rise at least SYNC_STAGES+1 clk cycles before the first sr_clk rising edge.
- busy equals (state == SHIFT), registered.

## Test plan
- Frame high, shift 8'b11001001 MSB-first with 10-clk sr_clk phases, no ack -> data_out = 8'hC9, data_valid = 1 two clks after the 8th sr_clk rise; frame_err = 0, overrun = 0.
- One frame carrying 8'h2A then 8'hC9, data_ack pulsed between them -> data_valid rises twice, data_out = 8'h2A then 8'hC9, no overrun, state returns to IDLE after frame falls.
- Same two words with data_ack never asserted -> overrun pulses exactly once, at the second completion; data_out = 8'hC9; data_valid remains 1.
- Frame falls after 5 bits of 8'hFF -> one frame_err pulse, data_valid stays 0, data_out stays 0. A following full frame carrying 8'h55 delivers 8'h55.
- Reset asserted for 1 clk after 3 bits -> all outputs 0 on the next edge. The next frame carrying 8'hA5 delivers 8'hA5, proving no stale bits remain.
- sr_clk toggling while frame = 0 -> no shifting, busy = 0, no valid, no error pulses.
